imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 152 +++++++++++++++
 tb/tb_imem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: 2^DEPTH_LOG2 x 16-bit array with fault flagging; optional next-word buffer under IMEM_PREFETCH_EN.
// Latency: WAIT+1 cycles from accepted req to instr_valid (1 cycle on a buffer hit).
// Backpressure: req is only sampled in IDLE (busy low); flush cancels a fetch still waiting.
module imem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        err
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [15:0] NOP     = 16'h0800;
    localparam logic [2:0]  WAIT_LD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] cap_addr;
    logic [15:0] rd_addr;
    logic [15:0] rd_dat;
    logic        rd_err;
    logic        accept;
    logic        hit;
    logic        enter_resp;
    logic [15:0] mem [DEPTH];

    function automatic logic in_range(input logic [15:0] a);
        return (a >> (DEPTH_LOG2 + 1)) == 16'd0;
    endfunction

    assign accept      = (state == S_IDLE) && req && !flush;
    assign rd_addr     = (state == S_IDLE) ? addr : cap_addr;
    assign instr_valid = (state == S_RESP);
    assign busy        = (state != S_IDLE);

`ifdef IMEM_PREFETCH_EN
    logic [15:0] pf_tag;
    logic [15:0] pf_dat;
    logic        pf_vld;
    logic [15:0] nxt_addr;
    logic        ld_ok;

    assign hit      = accept && pf_vld && (addr == pf_tag);
    assign nxt_addr = rd_addr + 16'd2;
    assign ld_ok    = ld_en && in_range(ld_addr);

    // A load landing on the same edge as the buffer fill would leave stale data, so the fill is marked invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_tag <= 16'h0000;
            pf_dat <= 16'h0000;
            pf_vld <= 1'b0;
        end else if (enter_resp) begin
            pf_tag <= nxt_addr;
            pf_dat <= mem[nxt_addr[DEPTH_LOG2:1]];
            pf_vld <= in_range(nxt_addr) && !nxt_addr[0] &&
                      !(ld_ok && (ld_addr[DEPTH_LOG2:1] == nxt_addr[DEPTH_LOG2:1]));
        end else if (pf_vld && ld_ok && (ld_addr[DEPTH_LOG2:1] == pf_tag[DEPTH_LOG2:1])) begin
            pf_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        rd_dat = mem[rd_addr[DEPTH_LOG2:1]];
        rd_err = rd_addr[0];
        if (!in_range(rd_addr)) begin
            rd_dat = NOP;
            rd_err = 1'b1;
        end
`ifdef IMEM_PREFETCH_EN
        if (hit) begin
            rd_dat = pf_dat;
            rd_err = 1'b0;
        end
`endif
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hit || (WAIT == 0)) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 3'd0;
                end else if (cnt == 3'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            cap_addr <= 16'h0000;
            instr    <= 16'h0000;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_addr <= addr;
            end
            if (enter_resp) begin
                instr <= rd_dat;
                err   <= rd_err;
            end
        end
    end

    // Array is deliberately left out of reset; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (ld_en && in_range(ld_addr)) begin
            mem[ld_addr[DEPTH_LOG2:1]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: random fetches/loads against a word-array + buffer model.
module tb_imem_responder;

    localparam int TW = 2;
`ifdef IMEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [15:0] addr = 16'h0;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [15:0] ld_data = 16'h0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        err;

    logic [15:0] model [256];
    logic [15:0] btag = 16'h0;
    bit          bvld = 1'b0;
    logic [15:0] last_a = 16'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    imem_responder #(.DEPTH_LOG2(8), .WAIT(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .instr(instr), .instr_valid(instr_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit in_rng(input logic [15:0] a);
        return a < 16'h0200;
    endfunction

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        if (in_rng(a)) begin
            model[int'(a >> 1)] = d;
            if (bvld && (a[15:1] == btag[15:1])) bvld = 1'b0;
        end
    endtask

    // Drives one fetch starting at a negedge and ends at the negedge after the response (IDLE).
    task automatic fetch(input string name, input logic [15:0] a, input bit do_ld,
                         input logic [15:0] la, input logic [15:0] ld_d, input bit flush_resp);
        int exp_lat, n;
        logic [15:0] exp_i;
        logic exp_e;
        bit is_hit;
        is_hit = PF && bvld && (a == btag);
        exp_lat = is_hit ? 0 : TW;
        if (!in_rng(a)) begin
            exp_i = 16'h0800; exp_e = 1'b1;
        end else begin
            exp_i = model[int'(a >> 1)]; exp_e = is_hit ? 1'b0 : a[0];
        end
        @(negedge clk);
        req = 1'b1; addr = a;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            ld_en = 1'b0;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_wait addr=%h cyc=%0d got=%b exp=1", name, a, n, busy);
            end
            if (do_ld && n == TW - 1) begin
                ld_en = 1'b1; ld_addr = la; ld_data = ld_d;
            end
            @(negedge clk);
            n++;
        end
        ld_en = 1'b0;
        n_checks++;
        if (n !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency addr=%h got=%0d exp=%0d", name, a, n, exp_lat);
        end
        n_checks++;
        if (instr !== exp_i || err !== exp_e) begin
            n_fail++;
            $display("FAIL %s data addr=%h got=%h/%b exp=%h/%b", name, a, instr, err, exp_i, exp_e);
        end
        if (flush_resp) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after addr=%h got=%b/%b exp=0/0", name, a, busy, instr_valid);
        end
        btag = a + 16'd2;
        bvld = PF && in_rng(btag) && !btag[0];
        if (do_ld && in_rng(la)) begin
            model[int'(la >> 1)] = ld_d;
            if (bvld && (la[15:1] == btag[15:1])) bvld = 1'b0;
        end
        last_a = a;
    endtask

    task automatic quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s quiet cyc=%0d got=%b/%b exp=0/0", name, i, instr_valid, busy);
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got=%h/%b/%b/%b exp=0000/0/0/0", instr, instr_valid, busy, err);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) load(16'(i * 2), (i == 8) ? 16'hA5C3 : 16'($urandom));
    endtask

    task automatic test_basic;
        fetch("basic_a5c3", 16'h0010, 1'b0, 16'h0, 16'h0, 1'b0);
        n_checks++;
        if (instr !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL basic_const got=%h exp=a5c3", instr);
        end
        fetch("back_to_back", 16'h0012, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_flush;
        @(negedge clk);
        req = 1'b1; flush = 1'b1; addr = 16'h0010;
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        quiet("flush_idle", 4);
        @(negedge clk);
        req = 1'b1; addr = 16'h0020;
        @(negedge clk);
        req = 1'b0; flush = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wait_busy got=%b exp=1", busy);
        end
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait_drop got=%b exp=0", busy);
        end
        quiet("flush_wait", 5);
        fetch("after_flush", 16'h0022, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("flush_resp", 16'h0024, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_errors;
        fetch("misaligned", 16'h0011, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("out_of_range", 16'h0400, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("oor_odd", 16'hFFFF, 1'b0, 16'h0, 16'h0, 1'b0);
        load(16'h0400, 16'hDEAD);
        fetch("ld_dropped", 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_load_collision;
        logic [15:0] old;
        old = model[24];
        fetch("ld_same_edge", 16'h0030, 1'b1, 16'h0030, 16'h1234, 1'b0);
        n_checks++;
        if (instr !== old) begin
            n_fail++;
            $display("FAIL ld_old_data got=%h exp=%h", instr, old);
        end
        fetch("ld_refetch", 16'h0030, 1'b0, 16'h0, 16'h0, 1'b0);
        n_checks++;
        if (instr !== 16'h1234) begin
            n_fail++;
            $display("FAIL ld_new_data got=%h exp=1234", instr);
        end
    endtask

    task automatic test_prefetch;
        fetch("pf_first", 16'h0040, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("pf_hit", 16'h0042, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("pf_refill", 16'h0040, 1'b0, 16'h0, 16'h0, 1'b0);
        load(16'h0042, 16'h5A5A);
        fetch("pf_invalidated", 16'h0042, 1'b0, 16'h0, 16'h0, 1'b0);
        fetch("pf_fill2", 16'h0050, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch("pf_after_flush", 16'h0052, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] a;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      a = 16'($urandom_range(0, 255) * 2);
            else if (r == 6) a = 16'($urandom_range(0, 255) * 2 + 1);
            else if (r == 7) a = 16'($urandom_range(16'h0200, 16'hFFFF));
            else             a = last_a + 16'd2;
            if ($urandom_range(0, 3) == 0) load(16'($urandom_range(0, 16'h03FF)), 16'($urandom));
            fetch("random", a, 1'b0, 16'h0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req = 1'b1; addr = 16'h0060;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h/%b/%b/%b exp=0000/0/0/0", instr, instr_valid, busy, err);
        end
        bvld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        quiet("after_reset", 6);
        fetch("post_reset", 16'h0062, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_errors();
        test_load_collision();
        if (PF) test_prefetch();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
